serial_add_controller: RTL and testbench
========================================

Name: serial_add_controller

Overview:
- Parallel-side driver and collector for the team's bit-serial adder (`serial_adder` / `serial_adder_using_logic_operations_only`).
- Accepts two W-bit operands over a valid/ready handshake, clears the adder carry, then streams both operands LSB-first onto the adder's `a`/`b` inputs.
- Captures the returning serial sum bits and presents the W-bit result over a valid/ready handshake.
- It is the word-level end of the serial add interface.

Parameters:
- W, default 8, operand and result width in bits; legal range W >= 2.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept an operand pair.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- ser_clr  output  1  carry clear; drives the adder's synchronous `rst` pin.
- ser_a  output  1  serial bit of A to the adder.
- ser_b  output  1  serial bit of B to the adder.
- ser_sum  input  1  combinational sum bit returned by the adder in the same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W (W+1 with the optional feature)  result.

Behaviour:
- Reset (async, rst=1): state IDLE; bit counter 0; shift registers 0.
  - Output values during reset: in_ready=0, ser_clr=0, ser_a=0, ser_b=0, out_valid=0, out_sum=0.
  - in_ready rises in the first cycle after rst deasserts.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, load in_a/in_b into shift registers and go to CLEAR.
  - CLEAR: exactly 1 cycle. ser_clr=1, ser_a=ser_b=0. Then go to SHIFT with counter=0.
  - SHIFT: ser_a=a_sh[0], ser_b=b_sh[0].
    - Every cycle: sample ser_sum into the MSB of sum_sh and shift sum_sh right by 1; shift a_sh/b_sh right by 1, shifting in 0; counter+1.
    - After counter reaches NBITS-1 (NBITS=W, or W+1 with the feature), go to DONE.
  - DONE: out_valid=1 and out_sum stable. On out_ready, go to IDLE.
- in_ready=0 in CLEAR, SHIFT and DONE. in_valid in those states is ignored; no buffering and no error.
- Latency: operand accepted on edge T -> out_valid high from edge T+W+2 (T+W+3 with the feature).
  - Throughput: one add per W+3 cycles when out_ready is held high.
- out_valid is held with out_sum constant while out_ready=0, for unbounded duration.
- ser_clr is high only in CLEAR; ser_a/ser_b are 0 outside SHIFT.
- Arithmetic: out_sum = (in_a + in_b) mod 2^W. The carry out of the MSB is discarded unless the feature is enabled.
- Reset mid-operation (any state): the transaction is aborted immediately.
  - No out_valid is produced for it; the next accept starts cleanly via CLEAR.
- Counter width: $clog2(W+2).
- No combinational path from in_valid or out_ready to any output other than through registered state.

Optional Feature:
- Macro: SERIAL_ADD_CARRY_OUT_EN.
- When defined:
  - out_sum is W+1 bits and SHIFT lasts W+1 cycles.
  - In the extra final cycle, ser_a=ser_b=0, so ser_sum equals the adder's final carry; it is captured as out_sum[W].
  - out_sum = in_a + in_b, full precision.
- When undefined: out_sum is W bits; SHIFT lasts W cycles; the carry is lost.

Decomposition:
- Package serial_add_pkg holds:
  - state enum typedef (IDLE, CLEAR, SHIFT, DONE), 2 bits;
  - localparam function for NBITS from W and the macro.
- One natural sub-module, serial_shift_reg:
  - parameterised width, load, shift-right-with-serial-in;
  - instantiated three times (a_sh, b_sh, sum_sh).
- FSM and counter stay in the top.

Test Plan:
- Bench wiring: DUT connected to `serial_adder`, with ser_clr driving the adder's `rst`; W=8.
- Single add: in_a=3, in_b=5 -> out_valid at T+10, out_sum=8; ser_clr high exactly 1 cycle at T+1.
- Overflow: in_a=255, in_b=1 -> out_sum=0x00; with SERIAL_ADD_CARRY_OUT_EN, out_sum=0x100 at T+11.
- Back-to-back with out_ready=1 and stale carry: 200+100 then 1+1 -> 44 then 2.
  - Confirms CLEAR zeroes the carry left over from the first add.
- Backpressure: out_ready=0 for 20 cycles after 7+9 -> out_valid and out_sum=16 held stable, in_ready=0 throughout.
  - Result accepted on the first cycle out_ready=1; in_ready=1 the next cycle.
- Busy/abort: in_valid pulsed with 1+1 during SHIFT of 10+20 -> ignored; result 30 only.
  - Then rst asserted mid-SHIFT of 50+60 -> outputs 0 asynchronously, no result.
  - Then 4+4 -> 8.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and sizing for the serial add controller.
// SERIAL_ADD_CARRY_OUT_EN widens the result by one bit to keep the final carry.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StShift,
    StDone
  } state_e;

  // Number of serial bit cycles, which is also the result width.
  function automatic int unsigned nbits(input int unsigned w);
`ifdef SERIAL_ADD_CARRY_OUT_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/serial_add_controller_if.sv
// Word-level handshakes plus the serial link to the bit-serial adder.
// The result width follows serial_add_pkg::nbits().
interface serial_add_controller_if #(
  parameter int unsigned W = 8
) ();

  logic                                in_valid;
  logic                                in_ready;
  logic [W-1:0]                        in_a;
  logic [W-1:0]                        in_b;
  logic                                ser_clr;
  logic                                ser_a;
  logic                                ser_b;
  logic                                ser_sum;
  logic                                out_valid;
  logic                                out_ready;
  logic [serial_add_pkg::nbits(W)-1:0] out_sum;

  modport slave (
    input  in_valid, in_a, in_b, ser_sum, out_ready,
    output in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, ser_sum, out_ready,
    input  in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
  );

endinterface

// File: rtl/serial_adder.sv
// Bit-serial full adder: combinational sum bit, carry held in a flop.
// rst is synchronous and clears only the carry.
module serial_adder (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic sum
);

  logic r_carry;

  assign sum = a ^ b ^ r_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= (a & b) | (a & r_carry) | (b & r_carry);
    end
  end

endmodule

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register, shifting right with a serial input at the MSB.
module serial_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;

  // Load wins over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_ser_in, r_q[Width-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_add_controller.sv
// Word-level driver/collector for the bit-serial adder: clears the carry, streams
// operands LSB-first and gathers the sum. SERIAL_ADD_CARRY_OUT_EN adds a carry bit.
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_add_controller_if.slave       bus
);

  localparam int unsigned NBits = nbits(W);
  localparam int unsigned CntW  = $clog2(W + 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBits - 1);

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             w_load;
  logic             w_shift;
  logic [W-1:0]     w_a_q;
  logic [W-1:0]     w_b_q;
  logic [NBits-1:0] w_sum_q;
  logic             w_unused_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ser_clr   = 1'b0;
    bus.ser_a     = 1'b0;
    bus.ser_b     = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Held low while reset is asserted so no handshake is seen mid-reset.
        bus.in_ready = ~rst;
        if (bus.in_valid && !rst) begin
          w_load      = 1'b1;
          w_state_nxt = StClear;
        end
      end
      StClear: begin
        bus.ser_clr = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = StShift;
      end
      StShift: begin
        bus.ser_a = w_a_q[0];
        bus.ser_b = w_b_q[0];
        w_shift   = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = StIdle;
        end
      end
    endcase
  end

  serial_shift_reg #(.Width(W)) u_a_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (bus.in_a),
    .i_shift    (w_shift),
    .i_ser_in   (1'b0),
    .o_q        (w_a_q)
  );

  serial_shift_reg #(.Width(W)) u_b_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (bus.in_b),
    .i_shift    (w_shift),
    .i_ser_in   (1'b0),
    .o_q        (w_b_q)
  );

  // After NBits shifts the first sampled bit sits at bit 0.
  serial_shift_reg #(.Width(NBits)) u_sum_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val ('0),
    .i_shift    (w_shift),
    .i_ser_in   (bus.ser_sum),
    .o_q        (w_sum_q)
  );

  assign bus.out_sum = w_sum_q;
  assign w_unused_hi = ^{w_a_q[W-1:1], w_b_q[W-1:1]};

endmodule

// File: tb/tb_serial_add_controller.sv
// Scoreboard bench: serial_add_controller wired to serial_adder, W=8, directed vectors.
module tb_serial_add_controller;
  import serial_add_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NB = nbits(W);
  localparam int Timeout = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_res = 0;
  logic [NB-1:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_controller_if #(.W(W)) bus ();

  serial_add_controller #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_adder u_adder (
    .clk (clk),
    .rst (bus.ser_clr),
    .a   (bus.ser_a),
    .b   (bus.ser_b),
    .sum (bus.ser_sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_res++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.out_sum);
      end else begin
        check("out_sum", 32'(bus.out_sum), 32'(sb.pop_front()));
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_ser_clr"},   32'(bus.ser_clr),   32'd0);
    check({tag, "_ser_a"},     32'(bus.ser_a),     32'd0);
    check({tag, "_ser_b"},     32'(bus.ser_b),     32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_sum"},   32'(bus.out_sum),   32'd0);
  endtask

  // Returns t_acc = cycle in which the handshake was presented; exits at posedge+1 of t_acc+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] full,
                      output int t_acc);
    int n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < Timeout);
    t_acc = cyc;
    check("in_accept", 32'(bus.in_ready), 32'd1);
    sb.push_back(full[NB-1:0]);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t_v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < Timeout);
    t_v = cyc;
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tv;
    logic [NB-1:0] dropped;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    #12;
    check_quiet("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single add 3+5, clear pulse, first shift bits, latency.
    send(8'd3, 8'd5, 9'd8, t0);
    @(negedge clk);
    check("clr_high", 32'(bus.ser_clr), 32'd1);
    check("clr_ser_a", 32'(bus.ser_a), 32'd0);
    @(negedge clk);
    check("clr_low", 32'(bus.ser_clr), 32'd0);
    check("shift_ser_a0", 32'(bus.ser_a), 32'd1);
    check("shift_ser_b0", 32'(bus.ser_b), 32'd1);
    check("shift_in_ready", 32'(bus.in_ready), 32'd0);
    wait_valid(tv);
    check("latency_3p5", 32'(tv - t0), 32'(NB + 2));

    // Overflow 255+1.
    send(8'd255, 8'd1, 9'h100, t0);
    wait_valid(tv);
    check("latency_ovf", 32'(tv - t0), 32'(NB + 2));

    // Back-to-back with a carry left over from 200+100.
    send(8'd200, 8'd100, 9'd300, t0);
    send(8'd1, 8'd1, 9'd2, t1);
    check("throughput", 32'(t1 - t0), 32'(NB + 3));
    drain();

    // Backpressure on 7+9.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(8'd7, 8'd9, 9'd16, t0);
    wait_valid(tv);
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.out_sum), 32'd16);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);

    // in_valid pulsed during SHIFT of 10+20 is ignored.
    send(8'd10, 8'd20, 9'd30, t0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd1;
    bus.in_b     = 8'd1;
    repeat (2) begin
      @(negedge clk);
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(tv);
    drain();
    repeat (NB + 6) @(negedge clk);

    // Reset in the middle of SHIFT of 50+60 aborts it.
    send(8'd50, 8'd60, 9'd110, t0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_quiet("abort");
    dropped = sb.pop_back();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (NB + 6) @(negedge clk);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);

    send(8'd4, 8'd4, 9'd8, t0);
    wait_valid(tv);
    check("latency_after_abort", 32'(tv - t0), 32'(NB + 2));
    drain();

    check("result_count", 32'(n_res), 32'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
